// File: rtl/bdiv_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : bdiv_seq_if
//  Description : Operand/result handshake bundle for the sequential signed
//                divider. The operand side carries dividend/divisor with
//                in_valid/in_ready. The result side carries quotient,
//                remainder, dbz and ovf with out_valid/out_ready.
//                  master : producer of operands, consumer of results
//                  slave  : the divider itself
//  Parameters  : W - operand width (dividend is 2W bits)
//  Revision    : 1.0 - initial release
// ============================================================================
interface bdiv_seq_if #(
    parameter int W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2*W-1:0]   dividend;
    logic [W-1:0]     divisor;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     quotient;
    logic [W-1:0]     remainder;
    logic             dbz;
    logic             ovf;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, dbz, ovf
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, dbz, ovf
    );
endinterface
`default_nettype wire

// File: rtl/bdiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bdiv_seq
//  Description : Sequential signed divider. A 2W-bit signed dividend is
//                divided by a W-bit signed divisor, giving a W-bit quotient
//                (truncated toward zero) and a W-bit remainder (sign of the
//                dividend, or zero). Magnitudes are divided by radix-2
//                restoring iteration, one quotient bit per clock, followed by
//                a sign-fix/saturation stage. Divide-by-zero and quotient
//                overflow produce saturated results with dbz/ovf flags.
//  Ports       : clk   - rising-edge clock
//                rst_n - synchronous active-low reset
//                bus   - bdiv_seq_if.slave (operand and result handshakes)
//  Option      : BDIV_EARLY_EXIT_EN - when defined, operations that are
//                already known to saturate (divide-by-zero or high-half
//                overflow) skip the full iteration sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module bdiv_seq #(
    parameter int W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    bdiv_seq_if.slave   bus
);

    localparam int CW = $clog2(W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CW-1:0] c_cnt_last = CW'(W - 1);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);
    localparam logic [W-1:0]  c_q_max    = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  c_q_min    = {1'b1, {(W-1){1'b0}}};

    logic [1:0]     r_state;
    logic [1:0]     w_state_nxt;

    logic [W-1:0]   r_rem;      // running partial remainder magnitude
    logic [W-1:0]   r_lo;       // dividend bits still to be shifted in
    logic [W-1:0]   r_dvs;      // divisor magnitude
    logic [W-1:0]   r_q;        // quotient magnitude being built
    logic [CW-1:0]  r_cnt;
    logic           r_sn;
    logic           r_sq;
    logic           r_dbz;
    logic           r_pre_ovf;

    logic [W-1:0]   r_quo;
    logic [W-1:0]   r_rmd;
    logic           r_dbz_o;
    logic           r_ovf_o;

    logic [2*W-1:0] w_dvd_mag;
    logic [W-1:0]   w_dvs_mag;
    logic           w_dbz_in;
    logic           w_pre_ovf_in;
    logic [W:0]     w_part;
    logic           w_ge;
    logic [W-1:0]   w_diff;
    logic           w_range_fail;
    logic [CW-1:0]  w_cnt_init;

    // Magnitudes: the most negative dividend/divisor still fit as unsigned.
    assign w_dvd_mag    = bus.dividend[2*W-1] ? -bus.dividend : bus.dividend;
    assign w_dvs_mag    = bus.divisor[W-1]    ? -bus.divisor  : bus.divisor;
    assign w_dbz_in     = (bus.divisor == '0);
    // If the high half already reaches the divisor, the quotient needs more
    // than W bits, so the result must saturate.
    assign w_pre_ovf_in = (w_dvd_mag[2*W-1:W] >= w_dvs_mag);

`ifdef BDIV_EARLY_EXIT_EN
    // A saturating operation makes a single pass through ITER with the
    // counter already at zero, so its result lands two edges after accept.
    assign w_cnt_init = (w_dbz_in | w_pre_ovf_in) ? '0 : c_cnt_last;
`else
    assign w_cnt_init = c_cnt_last;
`endif

    // One restoring step. When the high half is below the divisor the
    // partial remainder stays below 2*divisor, so the difference fits W bits.
    assign w_part = {r_rem, r_lo[W-1]};
    assign w_ge   = (w_part >= {1'b0, r_dvs});
    assign w_diff = w_part[W-1:0] - r_dvs;

    // Quotient magnitude outside the signed W-bit range for its sign.
    assign w_range_fail = r_sq ? (r_q[W-1] & (|r_q[W-2:0])) : r_q[W-1];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid)    w_state_nxt = S_ITER;
            S_ITER:  if (r_cnt == '0)     w_state_nxt = S_FIX;
            S_FIX:                        w_state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready)   w_state_nxt = S_IDLE;
            default:                      w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            S_IDLE:  bus.in_ready  = 1'b1;
            S_DONE:  bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.quotient  = r_quo;
    assign bus.remainder = r_rmd;
    assign bus.dbz       = r_dbz_o;
    assign bus.ovf       = r_ovf_o;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rem     <= '0;
            r_lo      <= '0;
            r_dvs     <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_sn      <= 1'b0;
            r_sq      <= 1'b0;
            r_dbz     <= 1'b0;
            r_pre_ovf <= 1'b0;
            r_quo     <= '0;
            r_rmd     <= '0;
            r_dbz_o   <= 1'b0;
            r_ovf_o   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_rem     <= w_dvd_mag[2*W-1:W];
                        r_lo      <= w_dvd_mag[W-1:0];
                        r_dvs     <= w_dvs_mag;
                        r_q       <= '0;
                        r_sn      <= bus.dividend[2*W-1];
                        r_sq      <= bus.dividend[2*W-1] ^ bus.divisor[W-1];
                        r_dbz     <= w_dbz_in;
                        r_pre_ovf <= w_pre_ovf_in;
                        r_cnt     <= w_cnt_init;
                    end
                end
                S_ITER: begin
                    r_rem <= w_ge ? w_diff : w_part[W-1:0];
                    r_lo  <= {r_lo[W-2:0], 1'b0};
                    r_q   <= {r_q[W-2:0], w_ge};
                    r_cnt <= r_cnt - c_cnt_one;
                end
                S_FIX: begin
                    if (r_dbz) begin
                        r_dbz_o <= 1'b1;
                        r_ovf_o <= 1'b0;
                        r_quo   <= r_sn ? c_q_min : c_q_max;
                        r_rmd   <= '0;
                    end else if (r_pre_ovf || w_range_fail) begin
                        r_dbz_o <= 1'b0;
                        r_ovf_o <= 1'b1;
                        r_quo   <= r_sq ? c_q_min : c_q_max;
                        r_rmd   <= '0;
                    end else begin
                        r_dbz_o <= 1'b0;
                        r_ovf_o <= 1'b0;
                        r_quo   <= r_sq ? -r_q : r_q;
                        r_rmd   <= r_sn ? -r_rem : r_rem;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bdiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bdiv_seq
//  Description : Self-checking bench for bdiv_seq (W=16). A table of directed
//                vectors with hand-computed results is run back to back,
//                followed by a result-hold sequence and a mid-iteration reset.
//                Honours BDIV_EARLY_EXIT_EN for the expected latency of
//                saturating operations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bdiv_seq;

    localparam int W        = 16;
    localparam int LAT_FULL = W + 1;
`ifdef BDIV_EARLY_EXIT_EN
    localparam int LAT_EARLY = 2;
`else
    localparam int LAT_EARLY = W + 1;
`endif
    localparam int NVEC = 16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    bdiv_seq_if #(.W(W)) bus ();

    bdiv_seq #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
        logic        o;
        bit          early;
    } vec_t;

    vec_t vecs [NVEC];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Presents one operand pair, counts edges from accept to out_valid.
    task automatic run_div(input logic [31:0] a, input logic [15:0] b,
                           output logic [15:0] q, output logic [15:0] r,
                           output logic z, output logic o, output int lat);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.dividend = '1;
        bus.divisor  = '1;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        q = bus.quotient;
        r = bus.remainder;
        z = bus.dbz;
        o = bus.ovf;
    endtask

    initial begin
        logic [15:0] q, r, hq, hr;
        logic        z, o;
        int          lat, seen;

        vecs[0]  = '{32'd100000,   16'd7,     16'h37CD, 16'h0005, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'hFFFE7960, 16'd7,     16'hC833, 16'hFFFB, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{32'd100000,   16'hFFF9,  16'hC833, 16'h0005, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{32'hFFFF8000, 16'd1,     16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{32'h00008000, 16'd1,     16'h7FFF, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{32'h40000000, 16'd2,     16'h7FFF, 16'h0000, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{32'd100000,   16'd0,     16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{32'hFFFFFFFB, 16'd0,     16'h8000, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{32'h80000000, 16'h8000,  16'h7FFF, 16'h0000, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{32'h40000000, 16'h8000,  16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{32'd7,        16'h8000,  16'h0000, 16'h0007, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{32'hFFFFFFF9, 16'd2,     16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{32'h7FFFFFFF, 16'h7FFF,  16'h7FFF, 16'h0000, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{32'h3FFF0006, 16'h7FFF,  16'h7FFF, 16'h0005, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{32'h80000000, 16'hFFFF,  16'h7FFF, 16'h0000, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{32'hFFFF7FFF, 16'd1,     16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0};

        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.quotient",  32'(bus.quotient),  32'd0);
        chk("rst.remainder", 32'(bus.remainder), 32'd0);
        chk("rst.dbz",       32'(bus.dbz),       32'd0);
        chk("rst.ovf",       32'(bus.ovf),       32'd0);
        rst_n = 1'b1;

        // Table of vectors, back to back with out_ready held high
        for (int i = 0; i < NVEC; i++) begin
            run_div(vecs[i].a, vecs[i].b, q, r, z, o, lat);
            chk($sformatf("v%0d.quotient", i),  32'(q), 32'(vecs[i].q));
            chk($sformatf("v%0d.remainder", i), 32'(r), 32'(vecs[i].r));
            chk($sformatf("v%0d.dbz", i),       32'(z), 32'(vecs[i].z));
            chk($sformatf("v%0d.ovf", i),       32'(o), 32'(vecs[i].o));
            chk($sformatf("v%0d.latency", i),   32'(lat),
                32'(vecs[i].early ? LAT_EARLY : LAT_FULL));
        end

        // Result held while the consumer stalls; in_valid ignored
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        run_div(32'd100000, 16'd7, q, r, z, o, lat);
        chk("hold.latency",  32'(lat), 32'(LAT_FULL));
        chk("hold.quotient", 32'(q),   32'h37CD);
        hq = q;
        hr = r;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.dividend = 32'd1000 + 32'(i);
            bus.divisor  = 16'd3;
            @(posedge clk); #1;
            chk($sformatf("hold%0d.out_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("hold%0d.in_ready", i),  32'(bus.in_ready),  32'd0);
            chk($sformatf("hold%0d.quotient", i),  32'(bus.quotient),  32'(hq));
            chk($sformatf("hold%0d.remainder", i), 32'(bus.remainder), 32'(hr));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release.out_valid", 32'(bus.out_valid), 32'd0);
        chk("release.in_ready",  32'(bus.in_ready),  32'd1);

        // Reset in the middle of ITER (counter at 8)
        bus.dividend = 32'd100000;
        bus.divisor  = 16'd7;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst.in_ready",  32'(bus.in_ready),  32'd1);
        chk("midrst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst.quotient",  32'(bus.quotient),  32'd0);
        chk("midrst.remainder", 32'(bus.remainder), 32'd0);
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        chk("midrst.no_result", 32'(seen), 32'd0);
        run_div(32'd1000, 16'd3, q, r, z, o, lat);
        chk("after.quotient",  32'(q),   32'd333);
        chk("after.remainder", 32'(r),   32'd1);
        chk("after.dbz",       32'(z),   32'd0);
        chk("after.ovf",       32'(o),   32'd0);
        chk("after.latency",   32'(lat), 32'(LAT_FULL));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
